grid_tile_renderer: RTL and testbench

Parametrised maze-grid renderer for the VGA path. It sits between the VGA driver's pixel-coordinate outputs and its colour input. It holds a GRID_ROWS × GRID_COLS array of 2-bit cell states, written over a valid/ready port, and maps each pixel to a colour through a 2-stage registered pipeline. It also supports whole-grid clear and a blinking robot-position marker timed off CLOCK_50.

---
 rtl/grid_tile_renderer_pkg.sv | 37 +++
 rtl/grid_tile_renderer_if.sv | 11 +
 rtl/grid_tile_renderer_blink_timer.sv | 31 +++
 rtl/grid_tile_renderer.sv | 152 +++++++++++++++
 tb/tb_grid_tile_renderer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_tile_renderer_pkg.sv
// Shared types and colour constants for the maze-grid renderer.
// Cell states, their RRRGGGBB colours and the write/clear FSM encoding.
package grid_pkg;

  typedef enum logic [1:0] {
    UNVISITED = 2'd0,
    VISITED   = 2'd1,
    WALL      = 2'd2,
    TREASURE  = 2'd3
  } cell_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsm_t;

  localparam logic [7:0] COLOR_UNVISITED = 8'h92;
  localparam logic [7:0] COLOR_VISITED   = 8'h1C;
  localparam logic [7:0] COLOR_WALL      = 8'hE0;
  localparam logic [7:0] COLOR_TREASURE  = 8'h03;
  localparam logic [7:0] COLOR_BG        = 8'h00;
  localparam logic [7:0] COLOR_LINE      = 8'hFF;
  localparam logic [7:0] COLOR_ROBOT     = 8'hFC;

  function automatic logic [7:0] cell_color(input cell_t c);
    logic [7:0] col;
    case (c)
      UNVISITED: col = COLOR_UNVISITED;
      VISITED:   col = COLOR_VISITED;
      WALL:      col = COLOR_WALL;
      TREASURE:  col = COLOR_TREASURE;
      default:   col = COLOR_BG;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/grid_tile_renderer_if.sv
// Cell write port of the grid renderer: valid/ready handshake plus target cell and state.
interface grid_tile_renderer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_col;
  logic [3:0] wr_row;
  logic [1:0] wr_state;

  modport master (output wr_valid, output wr_col, output wr_row, output wr_state, input wr_ready);
  modport slave  (input wr_valid, input wr_col, input wr_row, input wr_state, output wr_ready);
endinterface

// File: rtl/grid_tile_renderer_blink_timer.sv
// Free-running half-period timer: toggles blink_state and pulses wrap every BLINK_CYCLES clocks.
module blink_timer #(
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic blink_state,
  output logic wrap
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [CNT_W-1:0] count_reg;
  logic             blink_reg;

  assign wrap        = (count_reg == CNT_W'(BLINK_CYCLES - 1)) && !reset;
  assign blink_state = blink_reg;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_reg <= '0;
      blink_reg <= 1'b0;
    end else if (wrap) begin
      count_reg <= '0;
      blink_reg <= ~blink_reg;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/grid_tile_renderer.sv
// Maze-grid tile renderer: register-array cell store with write/clear FSM and a
// 2-stage pixel-to-colour pipeline with a blinking robot marker.
module grid_tile_renderer
  import grid_pkg::*;
#(
  parameter int GRID_COLS    = 4,
  parameter int GRID_ROWS    = 5,
  parameter int TILE_LOG2    = 6,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       pix_en,
  input  logic [9:0]                 pixel_x,
  input  logic [9:0]                 pixel_y,
  output logic [7:0]                 pixel_color,
  grid_tile_renderer_if.slave        wr,
  input  logic                       clear_req,
  output logic                       busy,
  input  logic [3:0]                 cur_col,
  input  logic [3:0]                 cur_row,
  output logic                       oob_err
);

  localparam int NUM_CELLS = GRID_ROWS * GRID_COLS;
  localparam int ADDR_W    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  fsm_t              state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic              oob_reg;
  logic              wr_fire, wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [2*NUM_CELLS-1:0] cells_flat;

  assign wr.wr_ready = (state_reg == IDLE) && !reset;
  assign busy        = (state_reg == CLEAR);
  assign oob_err     = oob_reg;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  // One spare bit so a 16-wide grid still compares correctly against 4-bit coordinates.
  assign wr_in_range = ({1'b0, wr.wr_col} < 5'(GRID_COLS)) && ({1'b0, wr.wr_row} < 5'(GRID_ROWS));
  assign wr_addr     = wr_in_range ? ADDR_W'(int'(wr.wr_row) * GRID_COLS + int'(wr.wr_col)) : '0;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        if (ptr_reg == ADDR_W'(NUM_CELLS - 1)) state_next = IDLE;
        else                                   ptr_next   = ptr_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      oob_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (wr_fire && !wr_in_range) oob_reg <= 1'b1;
    end
  end

  // A write and a clear_req in the same IDLE cycle: the write lands here, the clear sweeps it later.
  for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
    cell_t cell_reg;
    logic  cell_we;

    assign cell_we = ((state_reg == CLEAR) && (ptr_reg == ADDR_W'(gi)))
                   || (wr_fire && wr_in_range && (wr_addr == ADDR_W'(gi)));

    always_ff @(posedge CLOCK_50) begin
      if (reset)        cell_reg <= UNVISITED;
      else if (cell_we) cell_reg <= (state_reg == CLEAR) ? UNVISITED : cell_t'(wr.wr_state);
    end

    assign cells_flat[2*gi +: 2] = cell_reg;
  end

  logic blink_state;
  logic unused_blink_wrap;

  blink_timer #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .blink_state (blink_state),
    .wrap        (unused_blink_wrap)
  );

  // Stage 1: tile index and priority flags, compared at full 10-bit width to avoid aliasing.
  logic [9:0]        tile_col, tile_row;
  logic              pix_in_grid, pix_on_line, pix_robot;
  logic [ADDR_W-1:0] pix_addr;

  assign tile_col    = pixel_x >> TILE_LOG2;
  assign tile_row    = pixel_y >> TILE_LOG2;
  assign pix_in_grid = (tile_col < 10'(GRID_COLS)) && (tile_row < 10'(GRID_ROWS));
  assign pix_on_line = (pixel_x[TILE_LOG2-1:0] == '0) || (pixel_y[TILE_LOG2-1:0] == '0);
  assign pix_robot   = blink_state && (tile_col == {6'd0, cur_col}) && (tile_row == {6'd0, cur_row});
  assign pix_addr    = pix_in_grid ? ADDR_W'(int'(tile_row) * GRID_COLS + int'(tile_col)) : '0;

  logic              s1_valid_reg, s1_in_grid_reg, s1_line_reg, s1_robot_reg;
  logic [ADDR_W-1:0] s1_addr_reg;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s1_in_grid_reg <= 1'b0;
      s1_line_reg    <= 1'b0;
      s1_robot_reg   <= 1'b0;
      s1_addr_reg    <= '0;
    end else begin
      s1_valid_reg <= pix_en;
      if (pix_en) begin
        s1_in_grid_reg <= pix_in_grid;
        s1_line_reg    <= pix_on_line;
        s1_robot_reg   <= pix_robot;
        s1_addr_reg    <= pix_addr;
      end
    end
  end

  // Stage 2: cell lookup happens here so writes from the previous edge are already visible.
  cell_t      s1_cell;
  logic [7:0] color_next, pixel_color_reg;

  assign s1_cell = cell_t'(cells_flat[{s1_addr_reg, 1'b0} +: 2]);

  always_comb begin
    color_next = cell_color(s1_cell);
    if (!s1_in_grid_reg)  color_next = COLOR_BG;
    else if (s1_line_reg) color_next = COLOR_LINE;
    else if (s1_robot_reg) color_next = COLOR_ROBOT;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)             pixel_color_reg <= COLOR_BG;
    else if (s1_valid_reg) pixel_color_reg <= color_next;
  end

  assign pixel_color = pixel_color_reg;

endmodule

// File: tb/tb_grid_tile_renderer.sv
// Self-checking bench for grid_tile_renderer: fixed vectors, blink/clear/reset sequences
// and random writes/pixels against a tile-arithmetic reference model.
module tb_grid_tile_renderer;

  localparam int COLS  = 4;
  localparam int ROWS  = 5;
  localparam int TL    = 6;
  localparam int BLINK = 8;
  localparam int NC    = COLS * ROWS;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       clear_req = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [7:0] pixel_color;
  logic       busy, oob_err;
  logic [3:0] cur_col = 4'd15;
  logic [3:0] cur_row = 4'd15;

  grid_tile_renderer_if wr_if();

  grid_tile_renderer #(
    .GRID_COLS(COLS), .GRID_ROWS(ROWS), .TILE_LOG2(TL), .BLINK_CYCLES(BLINK)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .pix_en      (pix_en),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .wr          (wr_if),
    .clear_req   (clear_req),
    .busy        (busy),
    .cur_col     (cur_col),
    .cur_row     (cur_row),
    .oob_err     (oob_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  // Edges seen with reset low; blink phase is floor(edges / BLINK) mod 2.
  int nb_cnt = 0;
  always @(posedge CLOCK_50) begin
    if (reset) nb_cnt <= 0;
    else       nb_cnt <= nb_cnt + 1;
  end

  logic [1:0] cells_m [NC];
  bit         oob_m;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [7:0] state_color(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h92;
      2'd1:    return 8'h1C;
      2'd2:    return 8'hE0;
      default: return 8'h03;
    endcase
  endfunction

  function automatic bit blink_now();
    return ((nb_cnt / BLINK) % 2) == 1;
  endfunction

  function automatic logic [7:0] model_color(input int x, input int y, input int cc, input int cr, input bit blink);
    int tc, tr;
    tc = x / 64;
    tr = y / 64;
    if (tc >= COLS || tr >= ROWS) return 8'h00;
    if ((x % 64) == 0 || (y % 64) == 0) return 8'hFF;
    if (blink && tc == cc && tr == cr) return 8'hFC;
    return state_color(cells_m[tr * COLS + tc]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, got no response expected response", name);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic render_exp(input string name, input int x, input int y, input logic [7:0] exp);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    pix_en  = 1'b1;
    tick();
    pix_en = 1'b0;
    tick();
    chk(name, {24'd0, pixel_color}, {24'd0, exp});
  endtask

  task automatic render_model(input string name, input int x, input int y);
    render_exp(name, x, y, model_color(x, y, int'(cur_col), int'(cur_row), blink_now()));
  endtask

  task automatic do_write(input int c, input int r, input int s);
    int t;
    t = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_col   = 4'(c);
    wr_if.wr_row   = 4'(r);
    wr_if.wr_state = 2'(s);
    while (wr_if.wr_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) timeout_fail("wr_ready_wait");
    else begin
      tick();
      if (c < COLS && r < ROWS) cells_m[r * COLS + c] = 2'(s);
      else                      oob_m = 1'b1;
    end
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic blink_run(input string name, input int cycles);
    logic [7:0] exp_h [64];
    int seen_robot, seen_cell;
    seen_robot = 0;
    seen_cell  = 0;
    pixel_x = 10'd10;
    pixel_y = 10'd10;
    pix_en  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      exp_h[i] = model_color(10, 10, int'(cur_col), int'(cur_row), blink_now());
      tick();
      if (i > 0) begin
        chk(name, {24'd0, pixel_color}, {24'd0, exp_h[i-1]});
        if (pixel_color == 8'hFC) seen_robot++;
        else                      seen_cell++;
      end
    end
    pix_en = 1'b0;
    tick();
    chk({name, "_both_phases"}, {31'd0, (seen_robot >= 8 && seen_cell >= 8)}, 32'd1);
  endtask

  task automatic fill_all(input int s);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        do_write(c, r, s);
  endtask

  task automatic check_all_tiles(input string name);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        render_model(name, c * 64 + 32, r * 64 + 32);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, busy_cycles, pulse_done;
    bit ready_low_ok;
    logic [7:0] held;

    wr_if.wr_valid = 1'b0;
    wr_if.wr_col   = '0;
    wr_if.wr_row   = '0;
    wr_if.wr_state = '0;
    for (int i = 0; i < NC; i++) cells_m[i] = 2'd0;
    oob_m = 1'b0;

    tbl[0]  = '{x: 100,  y: 140,  exp: 8'h1C};
    tbl[1]  = '{x: 64,   y: 140,  exp: 8'hFF};
    tbl[2]  = '{x: 100,  y: 128,  exp: 8'hFF};
    tbl[3]  = '{x: 256,  y: 10,   exp: 8'h00};
    tbl[4]  = '{x: 512,  y: 10,   exp: 8'h00};
    tbl[5]  = '{x: 200,  y: 300,  exp: 8'hE0};
    tbl[6]  = '{x: 255,  y: 319,  exp: 8'hE0};
    tbl[7]  = '{x: 10,   y: 10,   exp: 8'h03};
    tbl[8]  = '{x: 10,   y: 320,  exp: 8'h00};
    tbl[9]  = '{x: 0,    y: 33,   exp: 8'hFF};
    tbl[10] = '{x: 1023, y: 1023, exp: 8'h00};
    tbl[11] = '{x: 65,   y: 65,   exp: 8'h92};

    repeat (3) tick();
    chk("reset_pixel_color", {24'd0, pixel_color}, 32'h00);
    chk("reset_wr_ready", {31'd0, wr_if.wr_ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_oob_err", {31'd0, oob_err}, 32'd0);
    reset = 1'b0;
    #1;
    chk("wr_ready_after_reset", {31'd0, wr_if.wr_ready}, 32'd1);

    render_exp("first_pixel_65_65", 65, 65, 8'h92);

    do_write(1, 2, 1);
    do_write(3, 4, 2);
    do_write(0, 0, 3);
    for (int i = 0; i < 12; i++) render_exp($sformatf("tbl%0d_x%0d_y%0d", i, tbl[i].x, tbl[i].y), tbl[i].x, tbl[i].y, tbl[i].exp);

    held = pixel_color;
    pixel_x = 10'd100;
    pixel_y = 10'd140;
    repeat (3) tick();
    chk("color_held_without_pix_en", {24'd0, pixel_color}, {24'd0, tbl[11].exp});

    do_write(5, 0, 2);
    chk("oob_err_set", {31'd0, oob_err}, 32'd1);
    check_all_tiles("tiles_after_oob");
    do_write(2, 2, 1);
    chk("oob_err_sticky", {31'd0, oob_err}, {31'd0, oob_m});
    render_model("write_after_oob", 160, 160);

    cur_col = 4'd0;
    cur_row = 4'd0;
    do_write(0, 0, 0);
    blink_run("blink_unvisited", 40);
    do_write(0, 0, 2);
    blink_run("blink_wall", 40);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_write(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      end else begin
        cur_col = 4'($urandom_range(0, 4));
        cur_row = 4'($urandom_range(0, 5));
        render_model($sformatf("rand%0d", i), int'($urandom_range(0, 300)), int'($urandom_range(0, 350)));
      end
    end
    chk("oob_err_random", {31'd0, oob_err}, {31'd0, oob_m});

    cur_col = 4'd15;
    cur_row = 4'd15;
    fill_all(3);
    check_all_tiles("tiles_treasure");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cycles = 0;
    ready_low_ok = 1'b1;
    pulse_done = 0;
    while (busy === 1'b1 && busy_cycles < 100) begin
      if (wr_if.wr_ready !== 1'b0) ready_low_ok = 1'b0;
      clear_req = (busy_cycles == 5);
      tick();
      busy_cycles++;
    end
    clear_req = 1'b0;
    if (busy_cycles >= 100) timeout_fail("clear_busy_wait");
    for (int i = 0; i < NC; i++) cells_m[i] = 2'd0;
    chk("clear_busy_cycles", busy_cycles, NC);
    chk("clear_wr_ready_low", {31'd0, ready_low_ok}, 32'd1);
    chk("clear_wr_ready_back", {31'd0, wr_if.wr_ready}, 32'd1);
    check_all_tiles("tiles_cleared");

    wr_if.wr_valid = 1'b1;
    wr_if.wr_col   = 4'd1;
    wr_if.wr_row   = 4'd1;
    wr_if.wr_state = 2'd2;
    clear_req      = 1'b1;
    tick();
    wr_if.wr_valid = 1'b0;
    clear_req      = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) timeout_fail("simul_clear_wait");
    chk("simul_write_clear_busy_cycles", n, NC);
    render_exp("simul_write_clear_tile", 96, 96, 8'h92);

    fill_all(3);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (7) tick();
    chk("mid_clear_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < NC; i++) cells_m[i] = 2'd0;
    oob_m = 1'b0;
    chk("reset_mid_clear_busy", {31'd0, busy}, 32'd0);
    chk("reset_mid_clear_wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
    chk("reset_mid_clear_oob", {31'd0, oob_err}, 32'd0);
    check_all_tiles("tiles_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
